instruction_fetch: RTL and testbench

- IF stage of the uDLX pipeline. Directly upstream of the decode stage.
- Owns the PC and runs a request/acknowledge handshake to instruction memory.
- Registers the fetched word and its PC into the IF/ID boundary.
- Handles stall, branch/jump redirect, and squash of in-flight fetches. Emits an all-zero word (decoder NOP) whenever no valid instruction is available.

---
 rtl/instruction_fetch_pkg.sv | 13 +
 rtl/instruction_fetch_pc_register.sv | 40 ++++
 rtl/instruction_fetch.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// uDLX IF stage shared definitions.
// Fetch FSM encodings and the decoder NOP word.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// uDLX IF stage program counter.
// Holds the PC, applies redirects and sequential increments.
module instruction_fetch_pc_register #(
  parameter int                  PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0] PC_RESET_VALUE = '0,
  parameter int                  PC_INCREMENT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_en_in,
  input  logic [PC_WIDTH-1:0] redirect_pc_in,
  input  logic                inc_en_in,
  output logic [PC_WIDTH-1:0] pc_out
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  // Redirect wins over increment; the add wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (redirect_en_in) begin
      pc_d = redirect_pc_in;
    end else if (inc_en_in) begin
      pc_d = pc_q + PC_WIDTH'(PC_INCREMENT);
    end
  end

  // PC storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= PC_RESET_VALUE;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// uDLX IF stage: PC, memory handshake, IF/ID register.
// Squash tracks a request whose data must be dropped.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                  INSTRUCTION_WIDTH = 32,
  parameter int                  PC_WIDTH          = 32,
  parameter logic [PC_WIDTH-1:0] PC_RESET_VALUE    = '0,
  parameter int                  PC_INCREMENT      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall_in,
  input  logic                         redirect_en_in,
  input  logic [PC_WIDTH-1:0]          redirect_pc_in,
  output logic                         inst_mem_rd_en_out,
  output logic [PC_WIDTH-1:0]          inst_mem_addr_out,
  input  logic                         inst_mem_ack_in,
  input  logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic                         inst_valid_out
);

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP =
    INSTRUCTION_WIDTH'(NOP_INSTRUCTION);

  if_state_t                    state_q, state_d;
  logic                         squash_q, squash_d;
  logic [PC_WIDTH-1:0]          squash_addr_q, squash_addr_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]          pc_out_q, pc_out_d;
  logic                         valid_q, valid_d;
  logic [INSTRUCTION_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [PC_WIDTH-1:0]          hold_pc_q, hold_pc_d;

  logic [PC_WIDTH-1:0] pc;
  logic                fetching;
  logic                ack;
  logic                pc_inc;

  assign fetching = (state_q != S_HOLD);
  assign ack      = fetching && inst_mem_ack_in;
  assign pc_inc   = ack && !squash_q;

  assign inst_mem_rd_en_out = fetching && !rst;
  assign inst_mem_addr_out  = squash_q ? squash_addr_q : pc;

  instruction_fetch_pc_register #(
    .PC_WIDTH       (PC_WIDTH),
    .PC_RESET_VALUE (PC_RESET_VALUE),
    .PC_INCREMENT   (PC_INCREMENT)
  ) u_pc (
    .clk            (clk),
    .rst            (rst),
    .redirect_en_in (redirect_en_in),
    .redirect_pc_in (redirect_pc_in),
    .inc_en_in      (pc_inc),
    .pc_out         (pc)
  );

  // Next-state: redirect, then accept, then hold drain, then wait.
  always_comb begin
    state_d       = state_q;
    squash_d      = squash_q;
    squash_addr_d = squash_addr_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    valid_d       = valid_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    if (redirect_en_in) begin
      instr_d      = NOP;
      valid_d      = 1'b0;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      state_d      = S_REQ;
      squash_d     = 1'b0;
      if (fetching && !inst_mem_ack_in) begin
        state_d       = S_WAIT;
        squash_d      = 1'b1;
        squash_addr_d = inst_mem_addr_out;
      end
    end else if (ack) begin
      state_d = S_REQ;
      if (squash_q) begin
        squash_d = 1'b0;
        if (!stall_in) begin
          instr_d = NOP;
          valid_d = 1'b0;
        end
      end else if (stall_in) begin
        hold_instr_d = inst_mem_data_in;
        hold_pc_d    = pc;
        state_d      = S_HOLD;
      end else begin
        instr_d  = inst_mem_data_in;
        pc_out_d = pc;
        valid_d  = 1'b1;
      end
    end else if (state_q == S_HOLD) begin
      if (!stall_in) begin
        instr_d  = hold_instr_q;
        pc_out_d = hold_pc_q;
        valid_d  = 1'b1;
        state_d  = S_REQ;
      end
    end else begin
      state_d = S_WAIT;
      if (!stall_in) begin
        instr_d = NOP;
        valid_d = 1'b0;
      end
    end
  end

  // State and IF/ID registers; reset drops an in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      squash_q      <= (state_q == S_WAIT);
      squash_addr_q <= PC_RESET_VALUE;
      instr_q       <= NOP;
      pc_out_q      <= '0;
      valid_q       <= 1'b0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      squash_q      <= squash_d;
      squash_addr_q <= squash_addr_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      valid_q       <= valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

  assign instruction_out = instr_q;
  assign pc_out          = pc_out_q;
  assign inst_valid_out  = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for the uDLX IF stage.
// Directed vector table, then random traffic against a queue model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect_en_in;
  logic [31:0] redirect_pc_in;
  logic        inst_mem_rd_en_out;
  logic [31:0] inst_mem_addr_out;
  logic        inst_mem_ack_in;
  logic [31:0] inst_mem_data_in;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        inst_valid_out;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .stall_in           (stall_in),
    .redirect_en_in     (redirect_en_in),
    .redirect_pc_in     (redirect_pc_in),
    .inst_mem_rd_en_out (inst_mem_rd_en_out),
    .inst_mem_addr_out  (inst_mem_addr_out),
    .inst_mem_ack_in    (inst_mem_ack_in),
    .inst_mem_data_in   (inst_mem_data_in),
    .instruction_out    (instruction_out),
    .pc_out             (pc_out),
    .inst_valid_out     (inst_valid_out)
  );

  typedef struct {
    logic        r, s, re;
    logic [31:0] rp;
    logic        a;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_in;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: next fetch address, a request whose data is to be
  // dropped, a parking queue for stalled words, and the IF/ID view.
  logic [31:0] m_pc = 32'h0;
  logic        m_drop = 1'b0;
  logic [31:0] m_drop_addr = 32'h0;
  logic        m_wait = 1'b0;
  logic [63:0] m_park[$];
  logic [31:0] m_in = 32'h0;
  logic [31:0] m_opc = 32'h0;
  logic        m_v = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2001_0005 : {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drop ? m_drop_addr : m_pc;
  endfunction

  task automatic add(input logic r, s, re, input logic [31:0] rp,
                     input logic a, erd, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ep, ei);
    vec_t v;
    v.r = r; v.s = s; v.re = re; v.rp = rp; v.a = a;
    v.e_rd = erd; v.e_addr = ea; v.e_v = ev; v.e_pc = ep; v.e_in = ei;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, s, re, input logic [31:0] rp,
                       input logic a);
    @(negedge clk);
    rst = r;
    stall_in = s;
    redirect_en_in = re;
    redirect_pc_in = rp;
    inst_mem_ack_in = a;
    inst_mem_data_in = word_at(m_addr());
    #1;
  endtask

  task automatic check(input string nm, input logic erd,
                       input logic [31:0] ea, input logic ev,
                       input logic [31:0] ep, ei);
    vectors++;
    if (inst_mem_rd_en_out !== erd ||
        (erd && inst_mem_addr_out !== ea) ||
        inst_valid_out !== ev || pc_out !== ep ||
        instruction_out !== ei) begin
      miscompares++;
      $display("FAIL %s: got rd=%b addr=%h v=%b pc=%h in=%h; want rd=%b addr=%h v=%b pc=%h in=%h",
               nm, inst_mem_rd_en_out, inst_mem_addr_out, inst_valid_out,
               pc_out, instruction_out, erd, ea, ev, ep, ei);
    end
  endtask

  task automatic model_step(input logic r, s, re, input logic [31:0] rp,
                            input logic a);
    logic        req;
    logic [31:0] addr;
    logic [63:0] e;
    req  = (m_park.size() == 0);
    addr = m_addr();
    if (r) begin
      m_drop = m_wait;
      m_drop_addr = 32'h0;
      m_wait = 1'b0;
      m_pc = 32'h0;
      m_park.delete();
      m_in = 32'h0; m_opc = 32'h0; m_v = 1'b0;
    end else if (re) begin
      m_in = 32'h0; m_v = 1'b0;
      m_park.delete();
      if (req && !a) begin
        m_drop = 1'b1; m_drop_addr = addr; m_wait = 1'b1;
      end else begin
        m_drop = 1'b0; m_wait = 1'b0;
      end
      m_pc = rp;
    end else if (req && a) begin
      m_wait = 1'b0;
      if (m_drop) begin
        m_drop = 1'b0;
        if (!s) begin m_in = 32'h0; m_v = 1'b0; end
      end else if (s) begin
        m_park.push_back({word_at(addr), addr});
        m_pc = m_pc + 32'd4;
      end else begin
        m_in = word_at(addr); m_opc = addr; m_v = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (!req) begin
      if (!s) begin
        e = m_park.pop_front();
        m_in = e[63:32]; m_opc = e[31:0]; m_v = 1'b1;
      end
    end else begin
      m_wait = 1'b1;
      if (!s) begin m_in = 32'h0; m_v = 1'b0; end
    end
  endtask

  initial begin
    logic        r, s, re, a;
    logic [31:0] rp;

    // Directed corner sequences.
    //   r  s  re rp            a  rd addr          v  pc            in
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h4,        1, 32'h0,        32'h2001_0005);
    add(0, 0, 0, 32'h0,        0, 1, 32'h8,        1, 32'h4,        32'hC0DE_0004);
    add(0, 0, 0, 32'h0,        0, 1, 32'h8,        0, 32'h4,        32'h0);
    add(0, 0, 0, 32'h0,        0, 1, 32'h8,        0, 32'h4,        32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h8,        0, 32'h4,        32'h0);
    add(0, 1, 0, 32'h0,        1, 1, 32'hC,        1, 32'h8,        32'hC0DE_0008);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        32'hC0DE_0008);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        32'hC0DE_0008);
    add(0, 0, 0, 32'h0,        0, 1, 32'h10,       1, 32'hC,        32'hC0DE_000C);
    add(0, 0, 1, 32'h100,      0, 1, 32'h10,       0, 32'hC,        32'h0);
    add(0, 0, 0, 32'h0,        0, 1, 32'h10,       0, 32'hC,        32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h10,       0, 32'hC,        32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h100,      0, 32'hC,        32'h0);
    add(0, 1, 1, 32'h200,      1, 1, 32'h104,      1, 32'h100,      32'hC0DE_0100);
    add(0, 0, 0, 32'h0,        0, 1, 32'h200,      0, 32'h100,      32'h0);
    add(0, 0, 0, 32'h0,        0, 1, 32'h200,      0, 32'h100,      32'h0);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100,      32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 1, 32'h4,        1, 32'h0,        32'h2001_0005);
    add(0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h4,       0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'h0,       32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h0,        1, 32'hFFFF_FFFC, 32'hC0DE_FFFC);
    add(0, 0, 0, 32'h0,        0, 1, 32'h4,        1, 32'h0,        32'h2001_0005);

    rst = 1'b1; stall_in = 1'b0; redirect_en_in = 1'b0;
    redirect_pc_in = 32'h0; inst_mem_ack_in = 1'b0;
    inst_mem_data_in = 32'h0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      model_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    end

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].re, tbl[i].rp, tbl[i].a);
      check($sformatf("tbl[%0d]", i), tbl[i].e_rd, tbl[i].e_addr,
            tbl[i].e_v, tbl[i].e_pc, tbl[i].e_in);
      model_step(tbl[i].r, tbl[i].s, tbl[i].re, tbl[i].rp, tbl[i].a);
    end

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      re = ($urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 1) == 1);
      rp = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF4;
      drive(r, s, re, rp, a);
      check($sformatf("rnd[%0d]", i), !r && (m_park.size() == 0),
            m_addr(), m_v, m_opc, m_in);
      model_step(r, s, re, rp, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
